vga_rx: RTL and testbench
=========================

Name: vga_rx

Overview:
- Receive-side counterpart of the VGA/LCD output interface: samples the parallel RGB565 pixel bus with hsync/vsync/de.
- Measures the incoming timing: visible width/height and sync widths.
- Packs visible pixels into 32-bit words and delivers them through a small FIFO with a valid/ready stream.
- Used as a loopback checker for the VGA controller and as a capture front-end for LCD/VGA sources; pixel clock equals clk_i.

Parameters:
FIFO_DEPTH, 4, packed-word FIFO entries (power of two, >=2)
CNT_WIDTH, 12, internal timing counter width (matches timing counter width); counters saturate at all-ones

Ports:
clk_i  in  1  pixel/system clock
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  receiver enable
hspol_i  in  1  1 = hsync active-high, 0 = active-low
vspol_i  in  1  1 = vsync active-high, 0 = active-low
vga_r_i  in  5  red
vga_g_i  in  6  green
vga_b_i  in  5  blue
vga_hsync_i  in  1  horizontal sync
vga_vsync_i  in  1  vertical sync
vga_de_i  in  1  data enable (visible region)
pix_valid_o  out  1  FIFO head valid
pix_ready_i  in  1  consumer ready
pix_data_o  out  32  packed pixels: [15:0] first pixel, [31:16] second pixel, RGB565 = {r,g,b}
pix_sof_o  out  1  head word is first word of a frame
meas_hvlen_o  out  16  measured visible pixels per line
meas_vvlen_o  out  16  measured visible lines per frame
meas_hsnsize_o  out  10  hsync width in clocks
meas_vsnsize_o  out  10  vsync width in lines
meas_vld_o  out  1  sticky: at least one frame measured
frame_done_o  out  1  1-cycle pulse at each frame commit
ovf_o  out  1  sticky FIFO overflow
ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset (rst_i=1 at a clock edge): all outputs 0, FIFO empty, all counters/shadows 0. Reset mid-frame discards the partial word and measurements.
- Input stage: all bus inputs registered once (stage S1). Syncs are normalised to active-high: hs = hsync ^ ~hspol_i, vs = vsync ^ ~vspol_i. Edges are detected against the previous S1 value.
- en_i=0: packer half-word cleared, FIFO flushed, timing counters held at 0, measured outputs retained. Enabling resumes at the next vs rising edge; nothing is pushed until then.
- Line measurement:
  - hcnt increments on each DE-high cycle.
  - On DE fall: hcnt -> shadow_h, lcnt += 1, hcnt <= 0.
  - On hs fall: hs_cnt (cycles hs high) -> meas_hsnsize_o, truncated to 10 bits.
- Frame commit on vs rise, applied only if lcnt != 0:
  - shadow_h -> meas_hvlen_o; lcnt -> meas_vvlen_o.
  - meas_vld_o <= 1; frame_done_o pulses 1 cycle; lcnt <= 0.
  - If lcnt == 0: no commit and no pulse.
- vsync width: count hs rising edges while vs is high; latch to meas_vsnsize_o on vs fall.
- Saturation: counters stop at 2^CNT_WIDTH-1; the value is zero-extended to 16 bits.
- Packer:
  - Even DE pixel -> low half; odd DE pixel completes the word and pushes it.
  - DE fall with a half-filled word pushes it with [31:16]=0.
  - A sof tag is set at vs rise and attached to the next pushed word, then cleared.
- Latency: the completing pixel at the ports in cycle t gives pix_valid_o=1 in cycle t+2 when the FIFO is empty.
- FIFO:
  - First-word-fall-through; pop when pix_valid_o & pix_ready_i.
  - Push while full without a same-cycle pop: the word is dropped and ovf_o <= 1.
  - Push while full with a same-cycle pop: the word is accepted.
  - Push while empty: head not visible until the next cycle.
- ovf_o: set has priority over a simultaneous ovf_clr_i.
- pix_data_o and pix_sof_o are stable while pix_valid_o=1 and pix_ready_i=0.

Test Plan:
- Frame of 8x4 visible, hsync 3, vsync 2 lines, both polarities high, pix_ready_i=1 -> 16 words, first with pix_sof_o=1. At second vs rise: meas_hvlen=8, vvlen=4, hsnsize=3, vsnsize=2, frame_done 1-cycle pulse, meas_vld=1.
- Same frame with hspol_i=vspol_i=0 and inverted syncs -> identical measurements and words.
- Line of 5 pixels 0x0001..0x0005 -> words 0x00020001, 0x00040003, 0x00000005.
- pix_ready_i=0 for a full 8-pixel line with FIFO_DEPTH=4 -> 4 words held, ovf_o=1 only if a fifth push occurs; ovf_clr_i on the same cycle as an overflow push -> ovf_o stays 1.
- rst_i asserted mid-line after 3 pixels -> next cycle all outputs 0; following frame measured correctly with no stale word.
- en_i dropped mid-frame then raised -> FIFO empty, no pushes until next vs rise, meas values retained throughout.

Source files
------------

// File: rtl/vga_rx_if.sv
// Packed-pixel stream leaving vga_rx: first-word-fall-through valid/ready with a start-of-frame tag.
interface vga_rx_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        sof;

    modport master (output valid, output data, output sof, input ready);
    modport slave  (input valid, input data, input sof, output ready);
endinterface

// File: rtl/vga_rx.sv
// VGA/LCD receive front-end: registers the RGB565 bus, measures line/frame timing,
// packs visible pixel pairs into 32-bit words and queues them in a small FWFT FIFO.
module vga_rx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         hspol_i,
    input  logic         vspol_i,
    input  logic [4:0]   vga_r_i,
    input  logic [5:0]   vga_g_i,
    input  logic [4:0]   vga_b_i,
    input  logic         vga_hsync_i,
    input  logic         vga_vsync_i,
    input  logic         vga_de_i,
    vga_rx_if.master     pix,
    output logic [15:0]  meas_hvlen_o,
    output logic [15:0]  meas_vvlen_o,
    output logic [9:0]   meas_hsnsize_o,
    output logic [9:0]   meas_vsnsize_o,
    output logic         meas_vld_o,
    output logic         frame_done_o,
    output logic         ovf_o,
    input  logic         ovf_clr_i
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {ST_WAIT, ST_RUN} state_t;
    state_t state, state_nx;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [15:0] pix_s1;
    logic        hs_s1, vs_s1, de_s1;
    logic        hs_d, vs_d, de_d;
    logic        hs_rise, hs_fall, vs_rise, vs_fall, de_fall;
    logic        run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_s1 <= '0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            de_s1  <= 1'b0;
            hs_d   <= 1'b0;
            vs_d   <= 1'b0;
            de_d   <= 1'b0;
        end else begin
            pix_s1 <= {vga_r_i, vga_g_i, vga_b_i};
            hs_s1  <= vga_hsync_i ^ ~hspol_i;
            vs_s1  <= vga_vsync_i ^ ~vspol_i;
            de_s1  <= vga_de_i;
            hs_d   <= hs_s1;
            vs_d   <= vs_s1;
            de_d   <= de_s1;
        end
    end

    assign hs_rise = hs_s1 & ~hs_d;
    assign hs_fall = ~hs_s1 & hs_d;
    assign vs_rise = vs_s1 & ~vs_d;
    assign vs_fall = ~vs_s1 & vs_d;
    assign de_fall = ~de_s1 & de_d;

    // Capture only starts on a vsync rising edge, so a partial frame is never measured or packed.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_WAIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        run      = 1'b0;
        case (state)
            ST_WAIT: begin
                if (en_i && vs_rise) begin
                    state_nx = ST_RUN;
                    run      = 1'b1;
                end
            end
            ST_RUN: begin
                if (en_i) run = 1'b1;
                else      state_nx = ST_WAIT;
            end
            default: state_nx = ST_WAIT;
        endcase
    end

    logic [CNT_WIDTH-1:0] hcnt, lcnt, hs_cnt, vs_cnt, shadow_h;
    logic [15:0]          half;
    logic                 half_vld;
    logic                 sof_tag;
    logic                 push;
    logic [31:0]          push_word;
    logic                 commit;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (run && half_vld) begin
            if (de_s1) begin
                push      = 1'b1;
                push_word = {pix_s1, half};
            end else if (de_fall) begin
                push      = 1'b1;
                push_word = {16'h0000, half};
            end
        end
    end

    assign commit = run & vs_rise & (lcnt != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || !run) begin
            hcnt     <= '0;
            lcnt     <= '0;
            hs_cnt   <= '0;
            vs_cnt   <= '0;
            shadow_h <= '0;
            half     <= '0;
            half_vld <= 1'b0;
            sof_tag  <= 1'b0;
        end else begin
            if (de_s1) begin
                hcnt <= sat_inc(hcnt);
            end else if (de_fall) begin
                shadow_h <= hcnt;
                lcnt     <= sat_inc(lcnt);
                hcnt     <= '0;
            end
            if (vs_rise) lcnt <= '0;

            hs_cnt <= hs_s1 ? sat_inc(hs_cnt) : '0;
            if (vs_rise)             vs_cnt <= hs_rise ? CNT_WIDTH'(1) : '0;
            else if (vs_s1 && hs_rise) vs_cnt <= sat_inc(vs_cnt);

            if (de_s1) begin
                if (half_vld) begin
                    half_vld <= 1'b0;
                end else begin
                    half     <= pix_s1;
                    half_vld <= 1'b1;
                end
            end else if (de_fall) begin
                half_vld <= 1'b0;
            end

            if (push)    sof_tag <= 1'b0;
            if (vs_rise) sof_tag <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meas_hvlen_o   <= '0;
            meas_vvlen_o   <= '0;
            meas_hsnsize_o <= '0;
            meas_vsnsize_o <= '0;
            meas_vld_o     <= 1'b0;
            frame_done_o   <= 1'b0;
        end else begin
            frame_done_o <= commit;
            if (commit) begin
                meas_hvlen_o <= 16'(shadow_h);
                meas_vvlen_o <= 16'(lcnt);
                meas_vld_o   <= 1'b1;
            end
            if (run && hs_fall) meas_hsnsize_o <= 10'(hs_cnt);
            if (run && vs_fall) meas_vsnsize_o <= 10'(vs_cnt);
        end
    end

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_ok;
    logic [32:0]   head;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = pix.valid & pix.ready;
    assign wr_ok     = push & (~full | pop);
    assign head      = mem[rd_ptr];
    assign pix.valid = (count != '0);
    assign pix.data  = pix.valid ? head[31:0] : '0;
    assign pix.sof   = pix.valid & head[32];

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr] <= {sof_tag, push_word};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A dropped word sets the flag even if a clear arrives in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i)                     ovf_o <= 1'b0;
        else if (push && full && !pop) ovf_o <= 1'b1;
        else if (ovf_clr_i)            ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx: frame-level model predicts packed words and timing measurements.
module tb_vga_rx;
    localparam int HSW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, en_i, hspol_i, vspol_i, ovf_clr_i;
    logic [4:0]  vga_r_i, vga_b_i;
    logic [5:0]  vga_g_i;
    logic        vga_hsync_i, vga_vsync_i, vga_de_i;
    logic [15:0] meas_hvlen_o, meas_vvlen_o;
    logic [9:0]  meas_hsnsize_o, meas_vsnsize_o;
    logic        meas_vld_o, frame_done_o, ovf_o;

    vga_rx_if pix();

    vga_rx #(.FIFO_DEPTH(4), .CNT_WIDTH(12)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .hspol_i(hspol_i), .vspol_i(vspol_i),
        .vga_r_i(vga_r_i), .vga_g_i(vga_g_i), .vga_b_i(vga_b_i),
        .vga_hsync_i(vga_hsync_i), .vga_vsync_i(vga_vsync_i), .vga_de_i(vga_de_i),
        .pix(pix.master),
        .meas_hvlen_o(meas_hvlen_o), .meas_vvlen_o(meas_vvlen_o),
        .meas_hsnsize_o(meas_hsnsize_o), .meas_vsnsize_o(meas_vsnsize_o),
        .meas_vld_o(meas_vld_o), .frame_done_o(frame_done_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    int errors = 0;
    int checks = 0;
    bit rst_b = 1'b1, en_b = 1'b1, clr_b = 1'b0, rdy_b = 1'b1, hp = 1'b1, vp = 1'b1;
    bit sb_on = 1'b0, m_run = 1'b0, m_sof = 1'b0, prev_vs = 1'b0;
    logic [32:0] exp_q [$];
    logic [32:0] got_q [$];
    int fd_cnt = 0;
    logic fd_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pixv(input int y, input int x);
        return 16'(y * 256 + x + 1);
    endfunction

    // One pixel clock; the model tracks arming (vsync rise while enabled) at frame level.
    task automatic cyc(input logic hs, input logic vs, input logic dv, input logic [15:0] p);
        @(posedge clk); #1;
        rst_i = rst_b; en_i = en_b; ovf_clr_i = clr_b; pix.ready = rdy_b;
        hspol_i = hp; vspol_i = vp;
        vga_hsync_i = hs ^ ~hp;
        vga_vsync_i = vs ^ ~vp;
        vga_de_i = dv;
        {vga_r_i, vga_g_i, vga_b_i} = dv ? p : 16'h0000;
        if (rst_b) begin
            m_run = 1'b0; m_sof = 1'b0; prev_vs = 1'b0;
            exp_q.delete();
        end else begin
            if (!en_b) begin
                m_run = 1'b0; m_sof = 1'b0;
            end else if (vs && !prev_vs) begin
                m_run = 1'b1; m_sof = 1'b1;
            end
            prev_vs = vs;
        end
    endtask

    task automatic line(input int w, input logic vs, input int y);
        for (int x = 0; x < w; x++) begin
            cyc(1'b0, vs, 1'b1, pixv(y, x));
            if (x % 2 == 1 && sb_on && m_run) begin
                exp_q.push_back({m_sof, pixv(y, x), pixv(y, x - 1)});
                m_sof = 1'b0;
            end
        end
        if (w % 2 == 1 && sb_on && m_run) begin
            exp_q.push_back({m_sof, 16'h0000, pixv(y, w - 1)});
            m_sof = 1'b0;
        end
        cyc(1'b0, vs, 1'b0, 16'h0); cyc(1'b0, vs, 1'b0, 16'h0);
        for (int i = 0; i < HSW; i++) cyc(1'b1, vs, 1'b0, 16'h0);
        cyc(1'b0, vs, 1'b0, 16'h0); cyc(1'b0, vs, 1'b0, 16'h0);
    endtask

    task automatic frame(input int w, input int h, input int nvs);
        for (int i = 0; i < nvs; i++) line(0, 1'b1, 0);
        line(0, 1'b0, 0);
        for (int y = 0; y < h; y++) line(w, 1'b0, y);
        line(0, 1'b0, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_meas(input string tag, input int h, input int v, input int hs, input int vs);
        check({tag, "_hvlen"}, 32'(meas_hvlen_o), 32'(h));
        check({tag, "_vvlen"}, 32'(meas_vvlen_o), 32'(v));
        check({tag, "_hsnsize"}, 32'(meas_hsnsize_o), 32'(hs));
        check({tag, "_vsnsize"}, 32'(meas_vsnsize_o), 32'(vs));
        check({tag, "_vld"}, 32'(meas_vld_o), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(pix.valid), 32'd0);
        check({tag, "_data"}, pix.data, 32'd0);
        check({tag, "_sof"}, 32'(pix.sof), 32'd0);
        check({tag, "_meas"}, {meas_hvlen_o, meas_vvlen_o}, 32'd0);
        check({tag, "_sn"}, {12'd0, meas_hsnsize_o, meas_vsnsize_o}, 32'd0);
        check({tag, "_flags"}, {29'd0, meas_vld_o, frame_done_o, ovf_o}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (frame_done_o === 1'b1) begin
            check("frame_done_width", 32'(fd_prev), 32'd0);
            fd_cnt++;
        end
        fd_prev = frame_done_o;
        if (pix.valid === 1'b1 && pix.ready === 1'b1) begin
            got_q.push_back({pix.sof, pix.data});
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", pix.data);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("word_data", pix.data, e[31:0]);
                    check("word_sof", 32'(pix.sof), 32'(e[32]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int fd0;
        rst_i = 1'b1; en_i = 1'b1; hspol_i = 1'b1; vspol_i = 1'b1; ovf_clr_i = 1'b0;
        vga_r_i = '0; vga_g_i = '0; vga_b_i = '0;
        vga_hsync_i = 1'b0; vga_vsync_i = 1'b0; vga_de_i = 1'b0;
        pix.ready = 1'b1;

        // Reset
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        rst_b = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check_zero("reset");

        // 8x4 frame, active-high syncs; first vsync only arms
        sb_on = 1'b1;
        line(0, 1'b0, 0);
        got_q.delete();
        frame(8, 4, 2);
        check("arm_no_commit_vld", 32'(meas_vld_o), 32'd0);
        check("arm_no_commit_fd", 32'(fd_cnt), 32'd0);
        line(0, 1'b1, 0);
        check_meas("f1", 8, 4, 3, 2);
        check("f1_frame_done", 32'(fd_cnt), 32'd1);
        wait_drain();
        check("f1_words", 32'(got_q.size()), 32'd16);
        check("f1_first_word", got_q[0][31:0], 32'h00020001);
        check("f1_first_sof", 32'(got_q[0][32]), 32'd1);
        check("f1_last_word", got_q[15][31:0], 32'h03080307);

        // Same frame with active-low syncs
        hp = 1'b0; vp = 1'b0;
        got_q.delete();
        frame(8, 4, 1);
        line(0, 1'b1, 0);
        check_meas("f2", 8, 4, 3, 2);
        check("f2_frame_done", 32'(fd_cnt), 32'd2);
        wait_drain();
        check("f2_words", 32'(got_q.size()), 32'd16);
        hp = 1'b1; vp = 1'b1;

        // Odd-length line: half word padded on DE fall
        got_q.delete();
        frame(5, 1, 1);
        line(0, 1'b1, 0);
        check_meas("f3", 5, 1, 3, 2);
        wait_drain();
        check("odd_words", 32'(got_q.size()), 32'd3);
        check("odd_w0", got_q[0][31:0], 32'h00020001);
        check("odd_w1", got_q[1][31:0], 32'h00040003);
        check("odd_w2", got_q[2][31:0], 32'h00000005);

        // Backpressure: latency, FIFO full, overflow with same-cycle clear
        line(0, 1'b0, 0);
        wait_drain();
        sb_on = 1'b0; rdy_b = 1'b0;
        got_q.delete();
        cyc(1'b0, 1'b0, 1'b1, 16'h0001);
        cyc(1'b0, 1'b0, 1'b1, 16'h0002);
        cyc(1'b0, 1'b0, 1'b1, 16'h0003);
        @(negedge clk);
        check("latency_t1_valid", 32'(pix.valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0004);
        @(negedge clk);
        check("latency_t2_valid", 32'(pix.valid), 32'd1);
        check("latency_t2_data", pix.data, 32'h00020001);
        check("latency_t2_sof", 32'(pix.sof), 32'd1);
        for (int x = 4; x < 8; x++) cyc(1'b0, 1'b0, 1'b1, pixv(0, x));
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check("full_no_ovf", 32'(ovf_o), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0101);
        cyc(1'b0, 1'b0, 1'b1, 16'h0102);
        clr_b = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        clr_b = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check("ovf_set_over_clear", 32'(ovf_o), 32'd1);
        check("held_head_data", pix.data, 32'h00020001);
        clr_b = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        clr_b = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check("ovf_cleared", 32'(ovf_o), 32'd0);
        rdy_b = 1'b1;
        repeat (8) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        check("bp_words", 32'(got_q.size()), 32'd4);
        check("bp_w3", got_q[3][31:0], 32'h00080007);
        sb_on = 1'b1;
        line(0, 1'b1, 0);

        // Reset mid-line after three pixels
        line(0, 1'b0, 0);
        wait_drain();
        sb_on = 1'b0;
        for (int x = 0; x < 3; x++) cyc(1'b0, 1'b0, 1'b1, pixv(7, x));
        rst_b = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        rst_b = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check_zero("midreset");
        got_q.delete();
        sb_on = 1'b1;
        fd0 = fd_cnt;
        frame(8, 4, 2);
        line(0, 1'b1, 0);
        check_meas("f5", 8, 4, 3, 2);
        check("f5_frame_done", 32'(fd_cnt - fd0), 32'd1);
        wait_drain();
        check("f5_words", 32'(got_q.size()), 32'd16);
        check("f5_first_word", got_q[0][31:0], 32'h00020001);

        // Enable dropped mid-frame: flush, hold off until next vsync rise
        line(0, 1'b1, 0);
        line(0, 1'b0, 0);
        wait_drain();
        sb_on = 1'b0; rdy_b = 1'b0;
        for (int x = 0; x < 4; x++) cyc(1'b0, 1'b0, 1'b1, pixv(9, x));
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check("pre_disable_valid", 32'(pix.valid), 32'd1);
        en_b = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check("disable_flush", 32'(pix.valid), 32'd0);
        rdy_b = 1'b1; sb_on = 1'b1;
        fd0 = fd_cnt;
        line(8, 1'b0, 10);
        check_meas("disabled", 8, 4, 3, 2);
        en_b = 1'b1;
        line(8, 1'b0, 11);
        @(negedge clk);
        check("reenable_no_push", 32'(pix.valid), 32'd0);
        check_meas("reenabled", 8, 4, 3, 2);
        frame(6, 3, 2);
        line(0, 1'b1, 0);
        check_meas("f6", 6, 3, 3, 2);
        check("f6_frame_done", 32'(fd_cnt - fd0), 32'd1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
